// File: rtl/router_merge4_pkg.sv
// Shared router types: port direction codes and block-wide constants.
package router_pkg;

  typedef enum logic [1:0] {
    PORT_SELF = 2'b00,
    PORT_NS   = 2'b01,
    PORT_WE   = 2'b10,
    PORT_DIAG = 2'b11
  } port_e;

  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/router_merge4_if.sv
// Flit bus for the 4-to-1 merge: four routed input channels plus one merged output.
interface router_merge4_if #(
  parameter int maxx   = 2,
  parameter int maxy   = 2,
  parameter int DATA_W = 8
);
  logic [3:0]             in_valid;
  logic [3:0]             in_ready;
  logic [3:0][maxx-1:0]   in_dst_x;
  logic [3:0][maxy-1:0]   in_dst_y;
  logic [3:0][DATA_W-1:0] in_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [maxx-1:0]        out_dst_x;
  logic [maxy-1:0]        out_dst_y;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             out_src;

  // Merge block side: consumes input channels, produces the merged flit.
  modport slave (
    input  in_valid, in_dst_x, in_dst_y, in_data, out_ready,
    output in_ready, out_valid, out_dst_x, out_dst_y, out_data, out_src
  );

  // Environment side: drives input channels, consumes the merged flit.
  modport master (
    output in_valid, in_dst_x, in_dst_y, in_data, out_ready,
    input  in_ready, out_valid, out_dst_x, out_dst_y, out_data, out_src
  );
endinterface

// File: rtl/router_merge4_arb.sv
// 4-way round-robin arbiter: first requester at or above ptr, wrapping modulo 4.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] gidx,
  output logic       any
);
  logic [1:0] idx;
  logic       found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    gidx  = '0;
    any   = |req;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant = any ? (4'b0001 << gidx) : 4'b0000;
  end
endmodule

// File: rtl/router_merge4.sv
// Merges the four routed-direction channels into one registered output stage
// with round-robin fairness and a saturating delivered-flit counter.
module router_merge4
  import router_pkg::*;
#(
  parameter int maxx   = 2,
  parameter int maxy   = 2,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  router_merge4_if.slave   bus,
  output logic [CNT_W-1:0] flit_cnt
);
  logic [NUM_PORTS-1:0] grant;
  logic [1:0]           gidx;
  logic                 any;
  logic                 free;
  logic                 accept;

  logic [1:0]        ptr_q,  ptr_d;
  logic              vld_q,  vld_d;
  port_e             src_q,  src_d;
  logic [maxx-1:0]   x_q,    x_d;
  logic [maxy-1:0]   y_q,    y_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  rr_arbiter4 u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // The output slot frees up either when empty or when it drains this cycle.
  assign free         = !vld_q || bus.out_ready;
  assign accept       = free && any && !rst;
  assign bus.in_ready = (free && !rst) ? grant : 4'b0000;

  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = vld_q;
    src_d  = src_q;
    x_d    = x_q;
    y_d    = y_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      vld_d  = 1'b1;
      src_d  = port_e'(gidx);
      x_d    = bus.in_dst_x[gidx];
      y_d    = bus.in_dst_y[gidx];
      data_d = bus.in_data[gidx];
      ptr_d  = gidx + 2'd1;
    end else if (free) begin
      vld_d  = 1'b0;
    end
    if (vld_q && bus.out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      vld_q  <= 1'b0;
      src_q  <= PORT_SELF;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      src_q  <= src_d;
      x_q    <= x_d;
      y_q    <= y_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_src   = src_q;
  assign bus.out_dst_x = x_q;
  assign bus.out_dst_y = y_q;
  assign bus.out_data  = data_q;
  assign flit_cnt      = cnt_q;
endmodule

// File: tb/tb_router_merge4.sv
// Self-checking bench for router_merge4: directed table, corner sequences, random vs model.
module tb_router_merge4;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flit_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  router_merge4_if #(.maxx(2), .maxy(2), .DATA_W(8)) bus ();

  router_merge4 #(.maxx(2), .maxy(2), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .flit_cnt (flit_cnt)
  );

  typedef struct {
    logic        r;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic o);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.out_ready = o;
    #1;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int p = 0; p < 4; p++) begin
      bus.in_data[p]  = 8'h50 + 8'(p);
      bus.in_dst_x[p] = 2'(p);
      bus.in_dst_y[p] = 2'(3 - p);
    end
  endtask

  task automatic chk_fields(input string name, input logic [1:0] s);
    chk({name, "_src"},  32'(bus.out_src),   32'(s));
    chk({name, "_data"}, 32'(bus.out_data),  32'(8'h50 + 8'(s)));
    chk({name, "_x"},    32'(bus.out_dst_x), 32'(s));
    chk({name, "_y"},    32'(bus.out_dst_y), 32'(2'd3 - s));
  endtask

  // Reference model state
  int          m_ptr;
  logic        m_ov;
  logic [1:0]  m_src, m_x, m_y;
  logic [7:0]  m_d;
  logic [15:0] m_cnt;

  initial begin
    logic [1:0] hold_src;
    logic [7:0] hold_d;
    rst           = 1'b1;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b0;
    set_pattern();

    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 16'd0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 16'd1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'd1};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd2};
    tbl[6]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'd2};
    tbl[7]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'd2};
    tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd3};
    tbl[9]  = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 16'd4};
    tbl[10] = '{1'b0, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1, 16'd5};
    tbl[11] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0};
    tbl[12] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].vld, tbl[i].ordy);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      step_edge();
      chk($sformatf("tbl%0d_ov", i),  32'(bus.out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_cnt", i), 32'(flit_cnt),      32'(tbl[i].cnt));
      if (tbl[i].ov) chk_fields($sformatf("tbl%0d", i), tbl[i].src);
    end

    // Single port with explicit payload and destination
    drive(1'b1, 4'h0, 1'b1);
    step_edge();
    bus.in_data[2]  = 8'hA5;
    bus.in_dst_x[2] = 2'd1;
    bus.in_dst_y[2] = 2'd2;
    drive(1'b0, 4'b0100, 1'b1);
    step_edge();
    chk("single_ov",   32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data),  32'hA5);
    chk("single_src",  32'(bus.out_src),   32'd2);
    chk("single_x",    32'(bus.out_dst_x), 32'd1);
    chk("single_y",    32'(bus.out_dst_y), 32'd2);
    drive(1'b0, 4'h0, 1'b1);
    step_edge();
    chk("single_cnt",  32'(flit_cnt),      32'd1);
    set_pattern();

    // Fairness: all ports requesting, full throughput
    drive(1'b1, 4'h0, 1'b1);
    step_edge();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'hF, 1'b1);
      step_edge();
      chk($sformatf("fair%0d_ov", i),  32'(bus.out_valid), 32'd1);
      chk($sformatf("fair%0d_cnt", i), 32'(flit_cnt),      32'(i));
      chk_fields($sformatf("fair%0d", i), 2'(i));
    end

    // Backpressure: the held flit (from port 3) must not move
    hold_src = bus.out_src;
    hold_d   = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'hF, 1'b0);
      chk($sformatf("bp%0d_ready", i), 32'(bus.in_ready), 32'd0);
      step_edge();
      chk($sformatf("bp%0d_ov", i),   32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_src", i),  32'(bus.out_src),   32'(hold_src));
      chk($sformatf("bp%0d_data", i), 32'(bus.out_data),  32'(hold_d));
    end
    drive(1'b0, 4'hF, 1'b1);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step_edge();
    chk_fields("bp_release", 2'd0);

    // Random traffic against the model
    drive(1'b1, 4'h0, 1'b0);
    step_edge();
    m_ptr = 0; m_ov = 1'b0; m_src = '0; m_x = '0; m_y = '0; m_d = '0; m_cnt = '0;
    for (int n = 0; n < 1500; n++) begin
      logic       r, o, free;
      logic [3:0] v, exp_rdy;
      int         g;
      r = ($urandom_range(0, 39) == 0);
      v = 4'($urandom);
      o = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) begin
        bus.in_data[p]  = 8'($urandom);
        bus.in_dst_x[p] = 2'($urandom);
        bus.in_dst_y[p] = 2'($urandom);
      end
      drive(r, v, o);
      free = !m_ov || o;
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_rdy = (!r && free && g >= 0) ? 4'(1 << g) : 4'h0;
      chk("rnd_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (r) begin
        m_ptr = 0; m_ov = 1'b0; m_src = '0; m_x = '0; m_y = '0; m_d = '0; m_cnt = '0;
      end else begin
        if (m_ov && o && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (free && g >= 0) begin
          m_ov  = 1'b1;
          m_src = 2'(g);
          m_x   = bus.in_dst_x[g];
          m_y   = bus.in_dst_y[g];
          m_d   = bus.in_data[g];
          m_ptr = (g + 1) % 4;
        end else if (free) begin
          m_ov  = 1'b0;
        end
      end
      step_edge();
      chk("rnd_ov",  32'(bus.out_valid), 32'(m_ov));
      chk("rnd_cnt", 32'(flit_cnt),      32'(m_cnt));
      if (m_ov) begin
        chk("rnd_src",  32'(bus.out_src),   32'(m_src));
        chk("rnd_x",    32'(bus.out_dst_x), 32'(m_x));
        chk("rnd_y",    32'(bus.out_dst_y), 32'(m_y));
        chk("rnd_data", 32'(bus.out_data),  32'(m_d));
      end
    end

    // Counter saturation after 65535 deliveries
    drive(1'b1, 4'h0, 1'b1);
    step_edge();
    drive(1'b0, 4'hF, 1'b1);
    repeat (65535) @(posedge clk);
    step_edge();
    chk("sat_reach", 32'(flit_cnt), 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_hold",  32'(flit_cnt), 32'hFFFF);
    chk("sat_ov",    32'(bus.out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
